// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a program source and the instruction-memory loader.
// The source drives valid/data and the loader returns ready.
interface imem_loader_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Writable instruction memory that is filled from a byte stream and guarded by a checksum.
// The processor is released through cpu_run only after a good checksum, and held again on halt.
module imem_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    imem_loader_if.slave      stream,
    input  logic [ADDR_W-1:0] prog_count,
    output logic [DATA_W-1:0] ins_val,
    input  logic              halt,
    output logic              cpu_run,
    output logic              load_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_RUN    = 3'd3,
        ST_HALTED = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [DATA_W-1:0] sum_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              cpu_run_r;
    logic              load_err_r;
    logic              in_ready_s;
    logic              accept_s;
    logic              wr_en_s;
    logic              clr_s;
    logic              err_set_s;

    // Running checksum is the plain modular byte sum of the program image.
    function automatic logic [DATA_W-1:0] sum_add(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] data);
        return acc + data;
    endfunction

    assign accept_s        = stream.in_valid & in_ready_s;
    assign stream.in_ready = in_ready_s;
    assign ins_val         = mem_r[prog_count];
    assign cpu_run         = cpu_run_r;
    assign load_err        = load_err_r;

    // Next-state and per-cycle strobes, decoded from the registered state.
    always_comb begin
        state_next_s = state_r;
        in_ready_s   = 1'b0;
        wr_en_s      = 1'b0;
        clr_s        = 1'b0;
        err_set_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALTED, ST_ERR: begin
                if (load_start) begin
                    state_next_s = ST_LOAD;
                    clr_s        = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LOAD: begin
                in_ready_s = 1'b1;
                if (accept_s) begin
                    wr_en_s = 1'b1;
                    if (wr_ptr_r == ADDR_W'(DEPTH - 1)) begin
                        state_next_s = ST_CHECK;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_CHECK: begin
                in_ready_s = 1'b1;
                if (accept_s) begin
                    if (stream.in_data == sum_r) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_ERR;
                        err_set_s    = 1'b1;
                    end
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Control registers: state, write pointer, checksum and the two status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= '0;
            sum_r      <= '0;
            cpu_run_r  <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cpu_run_r <= (state_next_s == ST_RUN);
            if (clr_s) begin
                wr_ptr_r <= '0;
                sum_r    <= '0;
            end else if (wr_en_s) begin
                // The pointer wraps to 0 after the last word, ready for the next load.
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
                sum_r    <= sum_add(sum_r, stream.in_data);
            end else begin
                wr_ptr_r <= wr_ptr_r;
                sum_r    <= sum_r;
            end
            if (clr_s) begin
                load_err_r <= 1'b0;
            end else if (err_set_s) begin
                load_err_r <= 1'b1;
            end else begin
                load_err_r <= load_err_r;
            end
        end
    end

    // Program storage; reset clears it so a discarded partial stream leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= stream.in_data;
        end else begin
            mem_r <= mem_r;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader: each record drives one cycle and
// states the outputs expected during that cycle.
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       load_start;
    logic       halt;
    logic [3:0] prog_count;
    logic [7:0] ins_val;
    logic       cpu_run;
    logic       load_err;

    imem_loader_if #(.DATA_W(8)) bus ();

    imem_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .stream     (bus),
        .prog_count (prog_count),
        .ins_val    (ins_val),
        .halt       (halt),
        .cpu_run    (cpu_run),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ls;
        logic       vld;
        logic [7:0] data;
        logic       hlt;
        logic [3:0] pc;
        logic       e_rdy;
        logic       e_run;
        logic       e_err;
        logic [7:0] e_ins;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s [%0d]: got %02h, expected %02h", name, idx, act, exp);
        end
    endtask

    task automatic push(input logic ls, input logic vld, input logic [7:0] data,
                        input logic hlt, input logic [3:0] pc, input logic e_rdy,
                        input logic e_run, input logic e_err, input logic [7:0] e_ins);
        vec_t v;
        v.ls = ls; v.vld = vld; v.data = data; v.hlt = hlt; v.pc = pc;
        v.e_rdy = e_rdy; v.e_run = e_run; v.e_err = e_err; v.e_ins = e_ins;
        vecs.push_back(v);
    endtask

    // Each record: drive at negedge, check 1ns later, the posedge then consumes the inputs.
    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            @(negedge clk);
            load_start   = vecs[i].ls;
            bus.in_valid = vecs[i].vld;
            bus.in_data  = vecs[i].data;
            halt         = vecs[i].hlt;
            prog_count   = vecs[i].pc;
            #1;
            check({tag, ".in_ready"}, i, {7'b0, bus.in_ready}, {7'b0, vecs[i].e_rdy});
            check({tag, ".cpu_run"},  i, {7'b0, cpu_run},      {7'b0, vecs[i].e_run});
            check({tag, ".load_err"}, i, {7'b0, load_err},     {7'b0, vecs[i].e_err});
            check({tag, ".ins_val"},  i, ins_val,              vecs[i].e_ins);
        end
        vecs.delete();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".in_ready"}, 0, {7'b0, bus.in_ready}, 8'h00);
        check({tag, ".cpu_run"},  0, {7'b0, cpu_run},      8'h00);
        check({tag, ".load_err"}, 0, {7'b0, load_err},     8'h00);
        for (int a = 0; a < 16; a++) begin
            prog_count = 4'(a);
            #1;
            check({tag, ".mem"}, a, ins_val, 8'h00);
        end
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b1;
        load_start   = 1'b0;
        halt         = 1'b0;
        prog_count   = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Good load of 0x10..0x1F with checksum 0x78; even steps probe the word being
        // written (not yet visible), odd steps probe the word written last cycle.
        push(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int j = 0; j < 16; j++) begin
            if (j % 2 == 0)
                push(1'b0, 1'b1, 8'(8'h10 + j), 1'b0, 4'(j), 1'b1, 1'b0, 1'b0, 8'h00);
            else
                push(1'b0, 1'b1, 8'(8'h10 + j), 1'b0, 4'(j - 1), 1'b1, 1'b0, 1'b0, 8'(8'h10 + j - 1));
        end
        push(1'b0, 1'b1, 8'h78, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 8'h1F);
        push(1'b0, 1'b0, 8'h00, 1'b0, 4'd5,  1'b0, 1'b1, 1'b0, 8'h15);
        push(1'b0, 1'b0, 8'h00, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 8'h1F);

        // Halt, then reload all-A5 in place: the word being written still shows its old value.
        push(1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'h10);
        push(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h10);
        push(1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h10);
        push(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h10);
        for (int j = 0; j < 16; j++)
            push(1'b0, 1'b1, 8'hA5, 1'b0, 4'(j), 1'b1, 1'b0, 1'b0, 8'(8'h10 + j));
        push(1'b0, 1'b1, 8'h50, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 8'hA5);
        for (int j = 0; j < 16; j++)
            push(1'b0, 1'b0, 8'h00, 1'b0, 4'(j), 1'b0, 1'b1, 1'b0, 8'hA5);

        // Gapped reload of 0x10..0x1F: junk on invalid cycles must be neither stored nor summed.
        push(1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'hA5);
        push(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'hA5);
        for (int j = 0; j < 16; j++) begin
            push(1'b0, 1'b1, 8'(8'h10 + j), 1'b0, 4'(j), 1'b1, 1'b0, 1'b0, 8'hA5);
            push(1'b0, 1'b0, 8'hEE,         1'b0, 4'(j), 1'b1, 1'b0, 1'b0, 8'(8'h10 + j));
        end
        push(1'b0, 1'b1, 8'h78, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h10);
        push(1'b0, 1'b0, 8'h00, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 8'h17);

        // Bad checksum 0x77 -> ERR; halt ignored there; load_start clears load_err.
        push(1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'h10);
        push(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h10);
        for (int j = 0; j < 16; j++)
            push(1'b0, 1'b1, 8'(8'h10 + j), 1'b0, 4'(j), 1'b1, 1'b0, 1'b0, 8'(8'h10 + j));
        push(1'b0, 1'b1, 8'h77, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h10);
        push(1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'h10);
        push(1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 8'h10);
        push(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 8'h10);

        // Partial load: 7 bytes, an ignored load_start, then bytes 8 and 9.
        for (int j = 0; j < 7; j++)
            push(1'b0, 1'b1, 8'(8'h30 + j), 1'b0, 4'(j), 1'b1, 1'b0, 1'b0, 8'(8'h10 + j));
        push(1'b1, 1'b0, 8'h00, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 8'h36);
        push(1'b0, 1'b1, 8'h37, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 8'h17);
        push(1'b0, 1'b1, 8'h38, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 8'h37);
        run_table("main");

        @(negedge clk);
        load_start   = 1'b0;
        bus.in_valid = 1'b0;
        prog_count   = 4'd8;
        #1;
        check("partial.ins_val", 8, ins_val, 8'h38);
        check("partial.in_ready", 0, {7'b0, bus.in_ready}, 8'h01);
        rst_n = 1'b0;
        #1;
        check_cleared("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh load after reset must start at word 0; load_start in RUN is ignored.
        push(1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int j = 0; j < 16; j++)
            push(1'b0, 1'b1, 8'(8'h40 + j), 1'b0, 4'(j), 1'b1, 1'b0, 1'b0, 8'h00);
        push(1'b0, 1'b1, 8'h78, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 8'h40);
        push(1'b0, 1'b0, 8'h00, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 8'h4F);
        push(1'b1, 1'b0, 8'h00, 1'b0, 4'd8,  1'b0, 1'b1, 1'b0, 8'h48);
        push(1'b0, 1'b0, 8'h00, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 8'h40);
        run_table("reload");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
